// File: rtl/lsu_hs_pkg.sv
// Shared constants and state type for the handshaked load/store unit.
// Instruction layout: [15:14] class, [13:12] mode, [11:10] register, [9:0] address.
package lsu_pkg;

  localparam logic [1:0] CLASS_MEM  = 2'b01;
  localparam logic [1:0] MODE_LOAD  = 2'b00;
  localparam logic [1:0] MODE_STORE = 2'b01;

  localparam int unsigned CLASS_LO = 14;
  localparam int unsigned MODE_LO  = 12;
  localparam int unsigned REG_LO   = 10;
  localparam int unsigned ADDR_HI  = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/lsu_hs_if.sv
// Point-to-point memory port: valid/ack request from the LSU (master) to memory (slave).
interface lsu_hs_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 16
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/lsu_hs_timeout_ctr.sv
// Wait-state counter for an outstanding memory request; o_expired flags the last
// allowed wait cycle so the LSU gives up after exactly TIMEOUT cycles of mem_req.
module lsu_timeout_ctr #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CntW'(1);
    end
  end

  assign o_expired = i_en && (r_count == LastCnt);

endmodule

// File: rtl/lsu_hs.sv
// Load/store unit: decodes memory instructions, issues a valid/ack memory request with
// timeout, and returns a one-cycle done/err pulse plus a one-hot register write on loads.
module lsu_hs
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned NUM_REGS  = 4,
  parameter int unsigned INSTR_W   = 16,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       instr_valid,
  input  logic [INSTR_W-1:0]         instr,
  output logic                       instr_ready,
  input  logic [NUM_REGS*DATA_W-1:0] reg_rdata,
  output logic [NUM_REGS-1:0]        reg_we,
  output logic [DATA_W-1:0]          reg_wdata,
  output logic                       done,
  output logic                       err,
  lsu_hs_if.master                   mem
);

  localparam int unsigned RegW = $clog2(NUM_REGS);

  lsu_state_t        r_state;
  lsu_state_t        w_state_d;
  logic [1:0]        r_mode;
  logic [RegW-1:0]   r_reg_idx;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic [1:0]          w_mode;
  logic [RegW-1:0]     w_reg_idx;
  logic                w_mode_ok;
  logic                w_accept;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_reg_sel;
  logic                w_in_req;
  logic                w_expired;
  logic                w_leave_req;
  logic                w_load_ok;
  logic [NUM_REGS-1:0] w_reg_onehot;

  assign w_mode    = instr[MODE_LO +: 2];
  assign w_reg_idx = instr[REG_LO +: RegW];
  assign w_mode_ok = (w_mode == MODE_LOAD) || (w_mode == MODE_STORE);
  assign w_accept  = (r_state == IDLE) && instr_valid && (instr[CLASS_LO +: 2] == CLASS_MEM);
  // Address arithmetic is done at ADDR_W so BASE_ADDR + field wraps naturally.
  assign w_addr    = ADDR_W'(BASE_ADDR) + ADDR_W'(instr[ADDR_HI:0]);

  always_comb begin
    w_reg_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_reg_idx == RegW'(i)) begin
        w_reg_sel = reg_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_in_req    = (r_state == REQ);
  assign w_leave_req = w_in_req && (mem.mem_ack || w_expired);

  lsu_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (!w_in_req || w_leave_req),
    .i_en      (w_in_req),
    .o_expired (w_expired)
  );

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_d = w_mode_ok ? REQ : RESP;
        end
      end
      REQ: begin
        if (w_leave_req) begin
          w_state_d = RESP;
        end
      end
      RESP:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_mode    <= '0;
      r_reg_idx <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_mode    <= w_mode;
        r_reg_idx <= w_reg_idx;
        r_addr    <= w_addr;
        r_wdata   <= w_reg_sel;
        r_err     <= !w_mode_ok;
      end else if (w_in_req) begin
        // Ack wins over a coincident timeout.
        if (mem.mem_ack) begin
          if (r_mode == MODE_LOAD) begin
            r_rdata <= mem.mem_rdata;
          end
        end else if (w_expired) begin
          r_err <= 1'b1;
        end
      end else if (r_state == RESP) begin
        r_err <= 1'b0;
      end
    end
  end

  always_comb begin
    w_reg_onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_reg_onehot[i] = (r_reg_idx == RegW'(i));
    end
  end

  assign instr_ready   = (r_state == IDLE);
  assign done          = (r_state == RESP);
  assign err           = done && r_err;
  assign w_load_ok     = done && !r_err && (r_mode == MODE_LOAD);
  assign reg_we        = w_load_ok ? w_reg_onehot : '0;
  assign reg_wdata     = r_rdata;

  assign mem.mem_req   = w_in_req;
  assign mem.mem_we    = w_in_req && (r_mode == MODE_STORE);
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = r_wdata;

endmodule
